// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR datapath: word-addressed RAM with
// programmable wait states and a level handshake (MemDone held until the request drops).
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Read,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  MemDone,
    output logic                  MemBusy,
    output logic                  MemErr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  isWrite_q, isWrite_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  errOut_q, errOut_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  request;
    logic                  addrOutOfRange;
    logic [IDX_W-1:0]      memIdx;

    assign request        = Read | Write;
    assign addrOutOfRange = ({1'b0, Address} >= (ADDR_WIDTH+1)'(DEPTH));
    assign memIdx         = addr_q[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        isWrite_d = isWrite_q;
        err_d     = err_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (request) begin
                    addr_d    = Address;
                    wdata_d   = WriteData;
                    isWrite_d = Write;
                    err_d     = (Read && Write) || addrOutOfRange;
                    cnt_d     = '0;
                    if (err_d) begin
                        state_d = S_DONE;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (!isWrite_q) begin
                    rdata_d = mem[memIdx];
                end
            end
            S_DONE: begin
                // done_q guard keeps an error completion visible for at least one cycle
                if (!request && done_q) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE);
        // Error requests sit one cycle in DONE before flagging, matching the WAIT_CYCLES=0 latency
        done_d   = (state_d == S_DONE) && (state_q != S_IDLE);
        errOut_d = done_d && err_d;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            isWrite_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            errOut_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            isWrite_q <= isWrite_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            errOut_q  <= errOut_d;
        end
    end

    // RAM is never reset; an async Clear forces IDLE so a pending write cannot land
    always_ff @(posedge Clock) begin
        if (state_q == S_ACCESS && isWrite_q) begin
            mem[memIdx] <= wdata_q;
        end
    end

    assign Mdatain = rdata_q;
    assign MemDone = done_q;
    assign MemBusy = busy_q;
    assign MemErr  = errOut_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written
// corner sequences and a randomized phase checked against a simple memory model.
module tb_mem_responder;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    logic        clock = 1'b0;
    logic        clear;
    logic        rdA, wrA, rdB, wrB;
    logic [8:0]  addrA;
    logic [9:0]  addrB;
    logic [31:0] wdA, wdB, mdA, mdB;
    logic        doneA, busyA, errA, doneB, busyB, errB;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clock = ~clock;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .WAIT_CYCLES(WAIT_A)) dutA (
        .Clock(clock), .Clear(clear), .Address(addrA), .WriteData(wdA), .Read(rdA), .Write(wrA),
        .Mdatain(mdA), .MemDone(doneA), .MemBusy(busyA), .MemErr(errA));

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(512), .WAIT_CYCLES(WAIT_B)) dutB (
        .Clock(clock), .Clear(clear), .Address(addrB), .WriteData(wdB), .Read(rdB), .Write(wrB),
        .Mdatain(mdB), .MemDone(doneB), .MemBusy(busyB), .MemErr(errB));

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        expErr;
        int          expLat;
        logic [31:0] expMd;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] memModel [512];
    logic [31:0] mdModel;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input int sel, input logic rd, input logic wr,
                            input logic [9:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            rdA = rd; wrA = wr; addrA = addr[8:0]; wdA = data;
        end else begin
            rdB = rd; wrB = wr; addrB = addr; wdB = data;
        end
    endtask

    // Issues one request, waits (bounded) for MemDone, drops the request and
    // samples the outputs one edge later. lat counts edges after the accept edge.
    task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                                 input logic [9:0] addr, input logic [31:0] data,
                                 output int lat, output logic [31:0] dout, output logic errFlag,
                                 output logic busyAfter, output logic doneAfter);
        @(negedge clock);
        driveReq(sel, rd, wr, addr, data);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            @(negedge clock);
            if ((sel == 0) ? doneA : doneB) begin
                lat = c;
                break;
            end
        end
        dout    = (sel == 0) ? mdA : mdB;
        errFlag = (sel == 0) ? errA : errB;
        driveReq(sel, 1'b0, 1'b0, addr, data);
        @(posedge clock);
        @(negedge clock);
        busyAfter = (sel == 0) ? busyA : busyB;
        doneAfter = (sel == 0) ? doneA : doneB;
    endtask

    function automatic vec_t mkVec(int sel, logic rd, logic wr, logic [9:0] addr,
                                   logic [31:0] data, logic expErr, logic [31:0] expMd);
        vec_t v;
        v.sel    = sel;
        v.rd     = rd;
        v.wr     = wr;
        v.addr   = addr;
        v.data   = data;
        v.expErr = expErr;
        v.expLat = expErr ? 1 : ((sel == 0) ? WAIT_A + 1 : WAIT_B + 1);
        v.expMd  = expMd;
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] dout;
        logic        eF, bA, dA;

        clear = 1'b0;
        driveReq(0, 1'b0, 1'b0, 10'd0, 32'd0);
        driveReq(1, 1'b0, 1'b0, 10'd0, 32'd0);
        #1;
        checkOutput("reset.busyA", busyA, 0);
        checkOutput("reset.doneA", doneA, 0);
        checkOutput("reset.mdA", mdA, 0);
        checkOutput("reset.errA", errA, 0);
        checkOutput("reset.busyB", busyB, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;

        // Abort a write mid-WAIT; the old content of addr 5 must survive
        applyStimulus(0, 1'b0, 1'b1, 10'd5, 32'h0BADF00D, lat, dout, eF, bA, dA);
        checkOutput("pre.wrLat", lat, WAIT_A + 1);
        applyStimulus(0, 1'b1, 1'b0, 10'd5, 32'h0, lat, dout, eF, bA, dA);
        checkOutput("pre.rdData", dout, 32'h0BADF00D);
        @(negedge clock);
        driveReq(0, 1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
        @(posedge clock);
        @(negedge clock);
        checkOutput("abort.busyBefore", busyA, 1);
        clear = 1'b0;
        #1;
        checkOutput("abort.busy", busyA, 0);
        checkOutput("abort.done", doneA, 0);
        checkOutput("abort.md", mdA, 0);
        driveReq(0, 1'b0, 1'b0, 10'd5, 32'h0);
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 10'd5, 32'h0, lat, dout, eF, bA, dA);
        checkOutput("abort.readLat", lat, WAIT_A + 1);
        checkOutput("abort.readback", dout, 32'h0BADF00D);

        vecs.push_back(mkVec(0, 0, 1, 10'd10,  32'h12345678, 0, 32'h0BADF00D));
        vecs.push_back(mkVec(0, 1, 0, 10'd10,  32'h0,        0, 32'h12345678));
        vecs.push_back(mkVec(0, 0, 1, 10'd3,   32'h33333333, 0, 32'h12345678));
        vecs.push_back(mkVec(0, 1, 1, 10'd3,   32'h44444444, 1, 32'h12345678));
        vecs.push_back(mkVec(0, 1, 0, 10'd3,   32'h0,        0, 32'h33333333));
        vecs.push_back(mkVec(0, 0, 1, 10'd511, 32'hCAFEF00D, 0, 32'h33333333));
        vecs.push_back(mkVec(0, 1, 0, 10'd511, 32'h0,        0, 32'hCAFEF00D));
        vecs.push_back(mkVec(0, 0, 1, 10'd0,   32'h00000001, 0, 32'hCAFEF00D));
        vecs.push_back(mkVec(0, 1, 0, 10'd0,   32'h0,        0, 32'h00000001));
        vecs.push_back(mkVec(1, 0, 1, 10'd0,   32'hA5A5A5A5, 0, 32'h0));
        vecs.push_back(mkVec(1, 1, 0, 10'd0,   32'h0,        0, 32'hA5A5A5A5));
        vecs.push_back(mkVec(1, 0, 1, 10'd88,  32'h88888888, 0, 32'hA5A5A5A5));
        vecs.push_back(mkVec(1, 0, 1, 10'd600, 32'hFFFF0000, 1, 32'hA5A5A5A5));
        vecs.push_back(mkVec(1, 1, 0, 10'd88,  32'h0,        0, 32'h88888888));
        vecs.push_back(mkVec(1, 0, 1, 10'd512, 32'h00000001, 1, 32'h88888888));
        vecs.push_back(mkVec(1, 0, 1, 10'd511, 32'h00005110, 0, 32'h88888888));
        vecs.push_back(mkVec(1, 1, 0, 10'd511, 32'h0,        0, 32'h00005110));
        vecs.push_back(mkVec(1, 1, 0, 10'd1023,32'h0,        1, 32'h00005110));
        vecs.push_back(mkVec(1, 1, 1, 10'd0,   32'h77777777, 1, 32'h00005110));
        vecs.push_back(mkVec(1, 1, 0, 10'd0,   32'h0,        0, 32'hA5A5A5A5));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                          lat, dout, eF, bA, dA);
            checkOutput($sformatf("vec%0d.lat", i), lat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d.err", i), eF, vecs[i].expErr);
            checkOutput($sformatf("vec%0d.md", i), dout, vecs[i].expMd);
            checkOutput($sformatf("vec%0d.busyAfter", i), bA, 0);
            checkOutput($sformatf("vec%0d.doneAfter", i), dA, 0);
        end

        // Hold Read past MemDone and move Address during WAIT
        applyStimulus(0, 1'b0, 1'b1, 10'd20, 32'h20202020, lat, dout, eF, bA, dA);
        applyStimulus(0, 1'b0, 1'b1, 10'd21, 32'h21212121, lat, dout, eF, bA, dA);
        @(negedge clock);
        driveReq(0, 1'b1, 1'b0, 10'd20, 32'h0);
        @(posedge clock);
        @(negedge clock);
        driveReq(0, 1'b1, 1'b0, 10'd21, 32'hFFFFFFFF);
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (doneA) begin
                lat = c;
                break;
            end
        end
        checkOutput("hold.lat", lat, WAIT_A + 1);
        checkOutput("hold.latchedData", mdA, 32'h20202020);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput($sformatf("hold.done%0d", k), doneA, 1);
        end
        checkOutput("hold.busyBeforeDrop", busyA, 1);
        driveReq(0, 1'b0, 1'b0, 10'd21, 32'h0);
        @(posedge clock);
        @(negedge clock);
        checkOutput("hold.busyAfterDrop", busyA, 0);
        checkOutput("hold.doneAfterDrop", doneA, 0);

        // Randomized phase on the WAIT_CYCLES=2 instance, addresses 16..31
        mdModel = 32'h20202020;
        for (int a = 16; a < 32; a++) begin
            memModel[a] = $urandom;
            applyStimulus(0, 1'b0, 1'b1, 10'(a), memModel[a], lat, dout, eF, bA, dA);
            checkOutput($sformatf("fill%0d.md", a), dout, mdModel);
        end
        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            logic        rd, wr, expErr;
            int          a;
            logic [31:0] d;
            kind   = $urandom_range(0, 9);
            rd     = (kind == 0) || (kind >= 5);
            wr     = (kind <= 4);
            a      = 16 + int'($urandom_range(0, 15));
            d      = $urandom;
            expErr = rd && wr;
            if (!expErr) begin
                if (wr) memModel[a] = d;
                else    mdModel = memModel[a];
            end
            applyStimulus(0, rd, wr, 10'(a), d, lat, dout, eF, bA, dA);
            checkOutput($sformatf("rnd%0d.lat", i), lat, expErr ? 1 : WAIT_A + 1);
            checkOutput($sformatf("rnd%0d.err", i), eF, expErr);
            checkOutput($sformatf("rnd%0d.md", i), dout, mdModel);
            checkOutput($sformatf("rnd%0d.busyAfter", i), bA, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's MAR/MDR datapath. It accepts read/write requests driven by the control unit through MAR (address) and MDR (write data). It services them against an internal word-addressed RAM after a programmable number of wait states. It returns read data on Mdatain, which feeds the MDR input mux, and signals completion with a level handshake so the control FSM can stall until memory is done.

Parameters:
DATA_WIDTH, 32, width of a memory word and of Mdatain/WriteData
ADDR_WIDTH, 9, width of the Address port
DEPTH, 512, number of implemented words (must be <= 2**ADDR_WIDTH)
WAIT_CYCLES, 2, wait states inserted between accept and array access (0..15)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Clear  input  1  asynchronous, active-low reset
Address  input  ADDR_WIDTH  word address from MAR
WriteData  input  DATA_WIDTH  store data from MDR output
Read  input  1  read request level from control unit
Write  input  1  write request level from control unit
Mdatain  output  DATA_WIDTH  registered read data to MDR mux
MemDone  output  1  request complete; held until request dropped
MemBusy  output  1  high whenever state != IDLE
MemErr  output  1  error status of the completed request, valid while MemDone=1

Behaviour:
- Reset (Clear=0, asynchronous): state=IDLE, wait counter=0, Mdatain=0, MemDone=0, MemBusy=0, MemErr=0. RAM contents are not reset.
- Reset mid-operation aborts immediately. A write whose ACCESS edge has not occurred is never committed.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: on a rising edge with (Read|Write)=1, latch Address, WriteData and op, then:
  - go to WAIT with counter=WAIT_CYCLES-1, or
  - go straight to ACCESS if WAIT_CYCLES=0.
- Error requests: Read=1 and Write=1 together, or Address>=DEPTH. These are accepted, skip WAIT/ACCESS, and go straight to DONE with MemErr=1.
  - No array write occurs and Mdatain is unchanged.
- WAIT: decrement counter each cycle. At counter=0, go to ACCESS next edge. Exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS: one cycle.
  - Read: Mdatain <= RAM[latched addr] on the exiting edge.
  - Write: RAM[latched addr] <= latched data on the exiting edge; Mdatain unchanged.
  - Then go to DONE.
- DONE: MemDone=1, plus MemErr=1 if this was an error request. Stay in DONE while (Read|Write)=1. When both are low, return to IDLE on the next edge, clearing MemDone and MemErr.
- Latency: a valid request accepted at edge E0 raises MemDone after edge E0+WAIT_CYCLES+1. An error request raises MemDone after edge E0+1.
- Request inputs change after accept: changes to Address, WriteData, Read or Write are ignored except for the drop-to-zero check in DONE. Latched values are used.
- Back-to-back requests: at least one IDLE cycle between requests (the handshake enforces it). A new request seen in the IDLE cycle is accepted normally.
- Read-after-write to the same address returns the newly written data.
- Mdatain holds its last value between reads.
- MemBusy is a registered decode of state and is high in WAIT, ACCESS and DONE.

Test Plan:
1. Reset with Clear=0 mid-WAIT of a write to addr 5 (data 0xDEADBEEF), then Clear=1 and read addr 5 -> MemBusy, MemDone and Mdatain are all 0 during reset. The readback shows the pre-reset content, not 0xDEADBEEF.
2. WAIT_CYCLES=2: write 0x12345678 to addr 10 and drop Write on MemDone, then read addr 10 -> MemDone rises 3 edges after each accept edge. Mdatain=0x12345678 when MemDone rises; MemErr=0.
3. WAIT_CYCLES=0: read addr 0 preloaded with 0xA5A5A5A5 -> MemDone and Mdatain=0xA5A5A5A5 one edge after accept.
4. Read=1 and Write=1 together at addr 3 -> MemDone=1 and MemErr=1 one edge after accept. RAM[3] and Mdatain are unchanged.
5. DEPTH=512, ADDR_WIDTH=10, write to addr 600 -> MemErr=1, no array write. A following read of addr 88 (600 mod 512) returns its old value.
6. Hold Read high for 5 cycles after MemDone, and change Address during WAIT -> MemDone stays 1 for all 5 cycles and the data comes from the latched address. IDLE is reached one edge after Read drops, and MemBusy falls with it.
